// File: rtl/mmul_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mmul_seq_ctrl
// Description : Job sequencer for the 3x3 matrix-multiply datapath
//               (mem_bank + matrix_multiplier). For each job it clears the
//               matrix memory, then accepts 9 W words and 9 X words from a
//               valid/ready stream and generates their row-major write
//               addresses. It then steps the MACs through the nine output
//               elements C[i][j] and offers each one on a result handshake.
//               Operand data goes straight from the stream into mem_bank;
//               this block drives only addresses, strobes and control.
// Ports       : clk, rst               - clock, synchronous active-high reset
//               start                  - begin a job (sampled only in IDLE)
//               in_valid / in_ready    - operand stream handshake
//               clear_mem              - one-cycle memory clear pulse
//               we_w, we_x             - bank write strobes
//               row_w, col_w           - W address (compute: row_w = i)
//               row_x, col_x           - X address (compute: col_x = j)
//               clear_mac, ld_mac      - MAC accumulator clear / load
//               res_valid / res_ready  - result handshake, index res_row/res_col
//               busy, done             - activity flag, completion pulse
// Revision    : 1.0 - initial release
// ============================================================================
module mmul_seq_ctrl #(
    parameter int N       = 3,
    parameter int AW      = 2,
    parameter int MAC_LAT = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          in_valid,
    output logic          in_ready,
    output logic          clear_mem,
    output logic          we_w,
    output logic          we_x,
    output logic [AW-1:0] row_w,
    output logic [AW-1:0] col_w,
    output logic [AW-1:0] row_x,
    output logic [AW-1:0] col_x,
    output logic          clear_mac,
    output logic          ld_mac,
    output logic          res_valid,
    input  logic          res_ready,
    output logic [AW-1:0] res_row,
    output logic [AW-1:0] res_col,
    output logic          busy,
    output logic          done
);

    localparam logic [3:0] S_IDLE   = 4'd0;
    localparam logic [3:0] S_CLEAR  = 4'd1;
    localparam logic [3:0] S_LOAD_W = 4'd2;
    localparam logic [3:0] S_LOAD_X = 4'd3;
    localparam logic [3:0] S_M_CLR  = 4'd4;
    localparam logic [3:0] S_M_LD   = 4'd5;
    localparam logic [3:0] S_M_WAIT = 4'd6;
    localparam logic [3:0] S_M_OUT  = 4'd7;
    localparam logic [3:0] S_DONE   = 4'd8;

    localparam logic [AW-1:0] c_LAST      = AW'(N - 1);
    localparam logic [AW-1:0] c_ONE       = AW'(1);
    // M_LD itself is the first latency cycle, so only MAC_LAT-1 wait cycles remain.
    localparam logic [2:0]    c_WAIT_INIT = 3'(MAC_LAT - 1);
    localparam logic [2:0]    c_WAIT_ONE  = 3'd1;

    logic [3:0]    r_state;
    logic [AW-1:0] r_lrow;   // load row counter
    logic [AW-1:0] r_lcol;   // load column counter
    logic [AW-1:0] r_i;      // output element row
    logic [AW-1:0] r_j;      // output element column
    logic [2:0]    r_wait;

    logic w_load_w;
    logic w_load_x;
    logic w_compute;

    assign w_load_w  = (r_state == S_LOAD_W);
    assign w_load_x  = (r_state == S_LOAD_X);
    assign w_compute = (r_state == S_M_CLR) || (r_state == S_M_LD) ||
                       (r_state == S_M_WAIT) || (r_state == S_M_OUT);

    // Strobes decode directly from the state register, so at most one is
    // ever active; write strobes follow in_valid so a word lands the same cycle.
    assign in_ready  = w_load_w || w_load_x;
    assign we_w      = w_load_w && in_valid;
    assign we_x      = w_load_x && in_valid;
    assign clear_mem = (r_state == S_CLEAR);
    assign clear_mac = (r_state == S_M_CLR);
    assign ld_mac    = (r_state == S_M_LD);
    assign res_valid = (r_state == S_M_OUT);
    assign busy      = (r_state != S_IDLE);
    assign done      = (r_state == S_DONE);

    assign row_w   = w_load_w ? r_lrow : (w_compute ? r_i : '0);
    assign col_w   = w_load_w ? r_lcol : '0;
    assign row_x   = w_load_x ? r_lrow : '0;
    assign col_x   = w_load_x ? r_lcol : (w_compute ? r_j : '0);
    assign res_row = r_i;
    assign res_col = r_j;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_lrow  <= '0;
            r_lcol  <= '0;
            r_i     <= '0;
            r_j     <= '0;
            r_wait  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) r_state <= S_CLEAR;
                end
                S_CLEAR: begin
                    r_lrow  <= '0;
                    r_lcol  <= '0;
                    r_i     <= '0;
                    r_j     <= '0;
                    r_state <= S_LOAD_W;
                end
                S_LOAD_W, S_LOAD_X: begin
                    // in_ready is high in both load states, so in_valid is the handshake.
                    if (in_valid) begin
                        if (r_lcol == c_LAST) begin
                            r_lcol <= '0;
                            if (r_lrow == c_LAST) begin
                                r_lrow  <= '0;
                                r_state <= w_load_w ? S_LOAD_X : S_M_CLR;
                            end else begin
                                r_lrow <= r_lrow + c_ONE;
                            end
                        end else begin
                            r_lcol <= r_lcol + c_ONE;
                        end
                    end
                end
                S_M_CLR: begin
                    r_state <= S_M_LD;
                end
                S_M_LD: begin
                    r_wait  <= c_WAIT_INIT;
                    r_state <= (c_WAIT_INIT == 3'd0) ? S_M_OUT : S_M_WAIT;
                end
                S_M_WAIT: begin
                    r_wait <= r_wait - c_WAIT_ONE;
                    if (r_wait <= c_WAIT_ONE) r_state <= S_M_OUT;
                end
                S_M_OUT: begin
                    if (res_ready) begin
                        if (r_j == c_LAST) begin
                            r_j <= '0;
                            if (r_i == c_LAST) begin
                                r_i     <= '0;
                                r_state <= S_DONE;
                            end else begin
                                r_i     <= r_i + c_ONE;
                                r_state <= S_M_CLR;
                            end
                        end else begin
                            r_j     <= r_j + c_ONE;
                            r_state <= S_M_CLR;
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mmul_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mmul_seq_ctrl
// Description : Self-checking bench for mmul_seq_ctrl. A main instance with
//               MAC_LAT=2 runs several jobs; two extra instances with
//               MAC_LAT=1 and MAC_LAT=7 share one job for latency timing.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mmul_seq_ctrl;

    localparam int c_LAT = 2;

    logic clk = 1'b0;
    logic rst, start, start_x, in_valid, res_ready;
    logic in_ready, clear_mem, we_w, we_x, clear_mac, ld_mac, res_valid, busy, done;
    logic [1:0] row_w, col_w, row_x, col_x, res_row, res_col;

    logic [1:0] e_in_ready, e_clear_mem, e_we_w, e_we_x, e_clear_mac, e_ld_mac;
    logic [1:0] e_res_valid, e_busy, e_done;
    logic [1:0] e_row_w [2];
    logic [1:0] e_col_w [2];
    logic [1:0] e_row_x [2];
    logic [1:0] e_col_x [2];
    logic [1:0] e_res_row [2];
    logic [1:0] e_res_col [2];

    always #5 clk = ~clk;

    mmul_seq_ctrl #(.N(3), .AW(2), .MAC_LAT(c_LAT)) u_dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .clear_mem(clear_mem), .we_w(we_w), .we_x(we_x),
        .row_w(row_w), .col_w(col_w), .row_x(row_x), .col_x(col_x),
        .clear_mac(clear_mac), .ld_mac(ld_mac), .res_valid(res_valid),
        .res_ready(res_ready), .res_row(res_row), .res_col(res_col),
        .busy(busy), .done(done)
    );

    for (genvar g = 0; g < 2; g++) begin : g_lat
        mmul_seq_ctrl #(.N(3), .AW(2), .MAC_LAT(g == 0 ? 1 : 7)) u_lat (
            .clk(clk), .rst(rst), .start(start_x), .in_valid(in_valid), .in_ready(e_in_ready[g]),
            .clear_mem(e_clear_mem[g]), .we_w(e_we_w[g]), .we_x(e_we_x[g]),
            .row_w(e_row_w[g]), .col_w(e_col_w[g]), .row_x(e_row_x[g]), .col_x(e_col_x[g]),
            .clear_mac(e_clear_mac[g]), .ld_mac(e_ld_mac[g]), .res_valid(e_res_valid[g]),
            .res_ready(res_ready), .res_row(e_res_row[g]), .res_col(e_res_col[g]),
            .busy(e_busy[g]), .done(e_done[g])
        );
    end

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    bit sb_en = 1'b0;

    logic [4:0] wq [$];   // {bank(1=X), row, col}
    logic [3:0] rq [$];   // {row, col}

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- monitor: scoreboard, latency, done timing ----------------
    logic [2:0] m_ld, m_rv, m_dn;
    assign m_ld = {e_ld_mac[1], e_ld_mac[0], ld_mac};
    assign m_rv = {e_res_valid[1], e_res_valid[0], res_valid};
    assign m_dn = {e_done[1], e_done[0], done};

    int lat_of [3] = '{2, 1, 7};
    int ldc [3];
    bit prv [3];
    int done_cyc [3];
    int done_cnt = 0;
    logic [4:0] m_we;
    logic [3:0] m_re;
    int m_nstb;

    always @(negedge clk) begin
        if (sb_en) begin
            m_nstb = int'(we_w) + int'(we_x) + int'(clear_mem) + int'(clear_mac) + int'(ld_mac);
            if (m_nstb != 0) check("strobe_mutex", m_nstb, 1);
            if (we_w || we_x) begin
                if (wq.size() == 0) check("write_unexpected", {we_x, we_w}, 0);
                else begin
                    m_we = wq.pop_front();
                    check("write_addr", {we_x, (we_x ? row_x : row_w), (we_x ? col_x : col_w)}, m_we);
                end
            end
            if (res_valid && res_ready) begin
                if (rq.size() == 0) check("result_unexpected", {res_row, res_col}, 4'hf);
                else begin
                    m_re = rq.pop_front();
                    check("result_index", {res_row, res_col}, m_re);
                end
            end
        end
        for (int k = 0; k < 3; k++) begin
            if (m_ld[k] === 1'b1) ldc[k] = cyc;
            if (m_rv[k] === 1'b1 && !prv[k])
                check($sformatf("latency_L%0d", lat_of[k]), cyc - ldc[k], lat_of[k]);
            prv[k] = (m_rv[k] === 1'b1);
            if (m_dn[k] === 1'b1) begin
                done_cyc[k] = cyc;
                if (k == 0) done_cnt++;
            end
        end
    end

    // ---------------- stimulus tasks (entered and left at posedge+1) ----------------
    task automatic push_results();
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                rq.push_back(4'((i << 2) | j));
    endtask

    task automatic start_job(input bit with_x, output int c0);
        c0      = cyc;
        start   = 1'b1;
        start_x = with_x;
        push_results();
        @(posedge clk); #1;
        start   = 1'b0;
        start_x = 1'b0;
        @(posedge clk); #1;   // CLEAR cycle
    endtask

    task automatic drive_words(input int from, input bit stall, input int ign_at);
        int m;
        for (int k = from; k < 18; k++) begin
            m        = k % 9;
            in_valid = 1'b1;
            start    = (k == ign_at);
            wq.push_back(5'(((k >= 9) ? 16 : 0) | ((m / 3) << 2) | (m % 3)));
            @(posedge clk); #1;
            start    = 1'b0;
            if (stall && k < 17) begin
                in_valid = 1'b0;
                repeat (2) begin @(posedge clk); #1; end
            end
        end
        in_valid = 1'b0;
        @(negedge clk);
        check("in_ready_after_load", in_ready, 0);
        check("writes_all_seen", wq.size(), 0);
        @(posedge clk); #1;
    endtask

    task automatic collect(input bit bp, input int ign_cyc);
        int acc = 0, hold = 0, n = 0, d0 = done_cnt;
        bit bp_done = 1'b0, seen = 1'b0;
        res_ready = 1'b1;
        while (!seen && n < 400) begin
            @(negedge clk);
            if (done) seen = 1'b1;
            if (res_valid && res_ready) acc++;
            if (bp && !bp_done && !res_ready && res_valid) begin
                check("bp_hold", {res_valid, res_row, res_col, ld_mac, clear_mac},
                      {1'b1, 2'd1, 2'd2, 1'b0, 1'b0});
                hold++;
                if (hold == 5) bp_done = 1'b1;
            end
            @(posedge clk); #1;
            res_ready = !(bp && !bp_done && acc == 5);
            start     = (ign_cyc >= 0 && cyc == ign_cyc);
            n++;
        end
        if (!seen) check("done_timeout", 0, 1);
        if (bp) check("bp_cycles", hold, 5);
        start     = 1'b0;
        res_ready = 1'b1;
        @(negedge clk);
        check("idle_after_done", {busy, done}, 0);
        check("done_pulses", done_cnt - d0, 1);
        check("results_all_seen", rq.size(), 0);
        repeat (3) @(negedge clk);
        check("stays_idle", busy, 0);
        @(posedge clk); #1;
    endtask

    // ---------------- main sequence ----------------
    typedef struct {
        logic       rst;
        logic       start;
        logic       iv;
        logic [8:0] exp;   // {busy, clear_mem, in_ready, we_w, done, row_w, col_w}
    } vec_t;

    vec_t tv [11];
    int   c0;
    int   nld, n;

    initial begin
        rst = 1'b1; start = 1'b0; start_x = 1'b0; in_valid = 1'b0; res_ready = 1'b0;
        repeat (2) @(posedge clk); #1;

        tv[0]  = '{1'b1, 1'b0, 1'b0, 9'b0_0_0_0_0_00_00};  // held in reset
        tv[1]  = '{1'b1, 1'b1, 1'b0, 9'b0_0_0_0_0_00_00};  // rst together with start
        tv[2]  = '{1'b0, 1'b0, 1'b0, 9'b0_0_0_0_0_00_00};  // rst won
        tv[3]  = '{1'b0, 1'b1, 1'b0, 9'b0_0_0_0_0_00_00};  // start sampled
        tv[4]  = '{1'b0, 1'b0, 1'b1, 9'b1_1_0_0_0_00_00};  // CLEAR, word ignored
        tv[5]  = '{1'b0, 1'b0, 1'b1, 9'b1_0_1_1_0_00_00};  // W(0,0)
        tv[6]  = '{1'b0, 1'b0, 1'b0, 9'b1_0_1_0_0_00_01};  // stall
        tv[7]  = '{1'b0, 1'b0, 1'b0, 9'b1_0_1_0_0_00_01};  // stall
        tv[8]  = '{1'b0, 1'b0, 1'b1, 9'b1_0_1_1_0_00_01};  // W(0,1)
        tv[9]  = '{1'b0, 1'b0, 1'b1, 9'b1_0_1_1_0_00_10};  // W(0,2)
        tv[10] = '{1'b0, 1'b0, 1'b1, 9'b1_0_1_1_0_01_00};  // W(1,0), row wrap

        push_results();
        for (int i = 0; i < 11; i++) begin
            rst = tv[i].rst; start = tv[i].start; in_valid = tv[i].iv;
            @(negedge clk);
            check($sformatf("vec%0d", i), {busy, clear_mem, in_ready, we_w, done, row_w, col_w}, tv[i].exp);
            @(posedge clk); #1;
        end
        start = 1'b0; res_ready = 1'b1;
        sb_en = 1'b1;

        // Job 1: remaining words with stalls, backpressure on element (1,2)
        drive_words(4, 1'b1, -1);
        collect(1'b1, -1);

        // Job 2: back-to-back, all three latencies, starts in LOAD_X and DONE ignored
        start_job(1'b1, c0);
        drive_words(0, 1'b0, 12);
        collect(1'b0, c0 + 1 + 18 + 9 * (c_LAT + 2) + 1);
        check("job_len_L2", done_cyc[0] - c0, 1 + 18 + 9 * (2 + 2) + 1);
        repeat (60) @(posedge clk); #1;
        check("job_len_L1", done_cyc[1] - c0, 1 + 18 + 9 * (1 + 2) + 1);
        check("job_len_L7", done_cyc[2] - c0, 1 + 18 + 9 * (7 + 2) + 1);

        // Job 3: reset during M_WAIT of element (0,1)
        start_job(1'b0, c0);
        drive_words(0, 1'b0, -1);
        nld = 0; n = 0;
        while (nld < 2 && n < 100) begin
            @(negedge clk);
            if (ld_mac) nld++;
            @(posedge clk); #1;
            n++;
        end
        check("second_ld_seen", nld, 2);
        rst = 1'b1;
        @(negedge clk);
        check("in_mwait_01", {busy, ld_mac, res_valid, res_row, res_col}, {1'b1, 1'b0, 1'b0, 2'd0, 2'd1});
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("reset_outputs", {in_ready, clear_mem, we_w, we_x, row_w, col_w, row_x, col_x,
                                clear_mac, ld_mac, res_valid, res_row, res_col, busy, done}, 0);
        rq.delete(); wq.delete();
        @(posedge clk); #1;

        // Job 4: fresh job after the reset
        start_job(1'b0, c0);
        drive_words(0, 1'b0, -1);
        collect(1'b0, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
`default_nettype wire
